cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Execution decision unit for the out-of-order core. Every cycle it picks one result from the issue/execute stage units (ALU, shift, multiply, …) and returns `canGo` to the winner, which frees that unit to accept its next reservation-station entry. The winning result goes into a single registered common-data-bus (CDB) slot read by the ROB and the reservation stations. Selection is oldest-first by ROB distance from the head pointer, so no unit can starve.

## Interface
Parameters:
- `NUM_UNITS`, 4: number of execute units arbitrated.
- `UNITLOG`, `$clog2(NUM_UNITS)`: width of the unit index.
- `ROBsize`, 16: ROB entries; valid tags are 0..ROBsize-1.
- `ROBsizeLog`, `$clog2(ROBsize+1)`: tag width.

Ports (clock and reset first):
- `clk_i`, in, 1: single clock; all state updates on its rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `unitValid_i`, in, NUM_UNITS: unit i holds a finished result (its `valid_o`).
- `unitTag_i`, in, NUM_UNITS*ROBsizeLog: ROB tag of unit i, packed, unit 0 in the LSBs.
- `unitVal_i`, in, NUM_UNITS*64: result of unit i, packed.
- `unitFlags_i`, in, NUM_UNITS*4: flags of unit i, packed.
- `robHead_i`, in, ROBsizeLog: tag of the oldest ROB entry.
- `cdbStall_i`, in, 1: consumers cannot accept a new CDB word this cycle.
- `flush_i`, in, 1: pipeline flush (branch mispredict).
- `canGo_o`, out, NUM_UNITS: one-hot or zero; grant to unit i (drives that unit's `canGo_i`).
- `cdbValid_o`, out, 1: CDB word valid.
- `cdbTag_o`, out, ROBsizeLog: CDB tag.
- `cdbVal_o`, out, 64: CDB result.
- `cdbFlags_o`, out, 4: CDB flags.
- `cdbUnit_o`, out, UNITLOG: index of the unit that produced the CDB word.

## Operation
- Age of unit i: `(unitTag_i[i] - robHead_i) mod ROBsize`. Compute it as `tag - head` if `tag >= head`, otherwise `tag + ROBsize - head`, using ROBsizeLog+1 bits internally. A smaller age means older.
- Candidate set: every i with `unitValid_i[i]` = 1.
- Winner: the candidate with the smallest age. If ages are equal (illegal duplicate tags), the lowest index wins.
- Grant condition: `grantEn = ~cdbStall_i & ~flush_i & ~reset_i & (candidate set nonempty)`.
- `canGo_o` is combinational. When `grantEn` is true, only the winner's bit is 1; otherwise `canGo_o` = 0.
- CDB register, priority order:
  1. reset or flush: `cdbValid_o` ← 0, all data fields ← 0.
  2. `cdbStall_i`: hold all CDB outputs.
  3. `grantEn`: capture the winner's tag, value, flags and index; `cdbValid_o` ← 1.
  4. Otherwise: `cdbValid_o` ← 0; the data fields hold their previous values.
- The block keeps no other state. Oldest-first selection is the starvation guarantee, because a waiting result's age only decreases as the ROB head advances.

## Timing
- Reset values: `cdbValid_o`=0, `cdbTag_o`=0, `cdbVal_o`=0, `cdbFlags_o`=0, `cdbUnit_o`=0. `canGo_o`=0 while `reset_i` is high.
- Latency: a grant in cycle N puts the word on the CDB in cycle N+1, one register stage. At the same edge the granted unit drops or replaces its result.
- Throughput: one CDB word per cycle while unstalled. Back-to-back grants to the same unit are allowed.
- `cdbStall_i` in cycle N: no grant, and the CDB word present in N is still present in N+1.
- `flush_i` in cycle N: no grant; `cdbValid_o`=0 in N+1. Flush beats stall.
- Wrap-around: if `robHead_i`=14, tag 15 (age 1) beats tag 1 (age 3), which beats tag 13 (age 15).
- `unitValid_i` low in cycle N: that unit never receives `canGo_o` in N.
- Reset asserted mid-stream: the CDB word is dropped at the next edge and no grant is issued in that cycle.

## Test plan
- Reset: hold `reset_i` for 2 cycles with all units valid → `canGo_o`=0, and `cdbValid_o`=0 and all CDB fields 0 in the cycle after reset.
- Oldest-first: head=0, units 0..3 valid with tags 5/2/9/7 → `canGo_o`=4'b0010. Next cycle: `cdbTag_o`=2, `cdbUnit_o`=1, `cdbVal_o`=unit 1's value.
- Wrap: head=14, tags 1/15/13/— (unit 3 invalid) → grant unit 1 (tag 15). Next grant, with unit 1 now invalid → unit 0 (tag 1), then unit 2 (tag 13).
- Stall: a CDB word with tag 3 is valid; assert `cdbStall_i` for 3 cycles with all units valid → `canGo_o`=0 and `cdbTag_o`=3 with `cdbValid_o`=1 throughout. On release, the oldest unit is granted the same cycle.
- Flush with stall: assert `flush_i` and `cdbStall_i` together while `cdbValid_o`=1 → `canGo_o`=0 and `cdbValid_o`=0 next cycle.
- Tie and back-to-back: units 0 and 2 both have tag 4 → unit 0 wins. Unit 0 stays valid with the oldest tag for 4 cycles → 4 consecutive grants to unit 0 and 4 consecutive valid CDB words.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: oldest-first selection of one execute-unit result per cycle.
// The winner receives a combinational canGo and its result is captured into
// a single registered common-data-bus slot read by the ROB and the
// reservation stations. Age is the ROB distance from the head pointer, so a
// waiting result only gets older as the head advances and cannot starve.
module cdb_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int UNITLOG    = $clog2(NUM_UNITS),
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [NUM_UNITS-1:0]             unitValid_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0]  unitTag_i,
  input  logic [NUM_UNITS*64-1:0]          unitVal_i,
  input  logic [NUM_UNITS*4-1:0]           unitFlags_i,
  input  logic [ROBsizeLog-1:0]            robHead_i,
  input  logic                             cdbStall_i,
  input  logic                             flush_i,
  output logic [NUM_UNITS-1:0]             canGo_o,
  output logic                             cdbValid_o,
  output logic [ROBsizeLog-1:0]            cdbTag_o,
  output logic [63:0]                      cdbVal_o,
  output logic [3:0]                       cdbFlags_o,
  output logic [UNITLOG-1:0]               cdbUnit_o
);

  // One extra bit so that tag + ROBsize - head cannot overflow.
  localparam int                AGE_W    = ROBsizeLog + 1;
  localparam logic [AGE_W-1:0]  ROB_SPAN = AGE_W'(ROBsize);

  logic [ROBsizeLog-1:0] tag   [NUM_UNITS];
  logic [63:0]           val   [NUM_UNITS];
  logic [3:0]            flags [NUM_UNITS];
  logic [AGE_W-1:0]      age   [NUM_UNITS];

  logic                  any_valid;
  logic [UNITLOG-1:0]    win_idx;
  logic [AGE_W-1:0]      win_age;
  logic                  grant_en;

  // Unpack the per-unit buses and compute each unit's age relative to the ROB head.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      tag[i]   = unitTag_i[i*ROBsizeLog +: ROBsizeLog];
      val[i]   = unitVal_i[i*64 +: 64];
      flags[i] = unitFlags_i[i*4 +: 4];
      if (tag[i] >= robHead_i) begin
        age[i] = {1'b0, tag[i]} - {1'b0, robHead_i};
      end else begin
        age[i] = {1'b0, tag[i]} + ROB_SPAN - {1'b0, robHead_i};
      end
    end
  end

  // Find the valid unit with the smallest age; strict '<' keeps the lowest index on ties.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    any_valid = 1'b0;
    win_idx   = '0;
    win_age   = '1;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unitValid_i[i] && (!any_valid || (age[i] < win_age))) begin
        any_valid = 1'b1;
        win_age   = age[i];
        win_idx   = UNITLOG'(i);
      end
    end
  end

  assign grant_en = ~cdbStall_i & ~flush_i & ~reset_i & any_valid;

  // Drive the one-hot grant back to the winning unit.
  always_comb begin
    canGo_o = '0;
    if (grant_en) begin
      canGo_o[win_idx] = 1'b1;
    end
  end

  // CDB slot: reset/flush clear it, stall holds it, a grant loads the winner.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i || flush_i) begin
      // NOTE: the data fields are cleared too because consumers see a defined all-zero word after reset or flush.
      cdbValid_o <= 1'b0;
      cdbTag_o   <= '0;
      cdbVal_o   <= '0;
      cdbFlags_o <= '0;
      cdbUnit_o  <= '0;
    end else if (cdbStall_i) begin
      cdbValid_o <= cdbValid_o;
    end else if (grant_en) begin
      cdbValid_o <= 1'b1;
      cdbTag_o   <= tag[win_idx];
      cdbVal_o   <= val[win_idx];
      cdbFlags_o <= flags[win_idx];
      cdbUnit_o  <= win_idx;
    end else begin
      cdbValid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with NUM_UNITS=4, ROBsize=16.
module tb_cdb_arbiter;

  localparam int NU = 4;
  localparam int TW = 5;   // $clog2(16+1)
  localparam int UW = 2;

  typedef enum logic [1:0] {CHK_NONE, CHK_ZERO, CHK_WORD} chk_e;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          stall;
    logic [TW-1:0] head;
    logic [NU-1:0] valid;
    logic [TW-1:0] t0, t1, t2, t3;
    logic [NU-1:0] exp_go;
    logic          exp_cv;
    chk_e          mode;
    logic [TW-1:0] exp_tag;
    logic [UW-1:0] exp_unit;
  } vec_t;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [NU-1:0]       unitValid_i;
  logic [NU*TW-1:0]    unitTag_i;
  logic [NU*64-1:0]    unitVal_i;
  logic [NU*4-1:0]     unitFlags_i;
  logic [TW-1:0]       robHead_i;
  logic                cdbStall_i;
  logic                flush_i;
  logic [NU-1:0]       canGo_o;
  logic                cdbValid_o;
  logic [TW-1:0]       cdbTag_o;
  logic [63:0]         cdbVal_o;
  logic [3:0]          cdbFlags_o;
  logic [UW-1:0]       cdbUnit_o;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter #(.NUM_UNITS(NU), .ROBsize(16)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .unitValid_i (unitValid_i),
    .unitTag_i   (unitTag_i),
    .unitVal_i   (unitVal_i),
    .unitFlags_i (unitFlags_i),
    .robHead_i   (robHead_i),
    .cdbStall_i  (cdbStall_i),
    .flush_i     (flush_i),
    .canGo_o     (canGo_o),
    .cdbValid_o  (cdbValid_o),
    .cdbTag_o    (cdbTag_o),
    .cdbVal_o    (cdbVal_o),
    .cdbFlags_o  (cdbFlags_o),
    .cdbUnit_o   (cdbUnit_o)
  );

  always #5 clk_i = ~clk_i;

  // Each unit's result and flags are a fixed function of its index and tag,
  // so the expected CDB word follows from the expected winner alone.
  function automatic logic [63:0] val_of(int u, logic [TW-1:0] t);
    return 64'hC0DE_0000_0000_0000 + (64'(u) << 16) + 64'(t);
  endfunction

  function automatic logic [3:0] flags_of(int u, logic [TW-1:0] t);
    return 4'((u << 2) ^ int'(t));
  endfunction

  function automatic vec_t mk(logic rst, logic flush, logic stall,
                              logic [TW-1:0] head, logic [NU-1:0] valid,
                              logic [TW-1:0] t0, logic [TW-1:0] t1,
                              logic [TW-1:0] t2, logic [TW-1:0] t3,
                              logic [NU-1:0] go, logic cv, chk_e mode,
                              logic [TW-1:0] et, logic [UW-1:0] eu);
    vec_t v;
    v.rst = rst; v.flush = flush; v.stall = stall; v.head = head; v.valid = valid;
    v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
    v.exp_go = go; v.exp_cv = cv; v.mode = mode; v.exp_tag = et; v.exp_unit = eu;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check canGo mid-cycle, then the CDB after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [TW-1:0] tg [NU];
    tg[0] = v.t0; tg[1] = v.t1; tg[2] = v.t2; tg[3] = v.t3;
    reset_i     = v.rst;
    flush_i     = v.flush;
    cdbStall_i  = v.stall;
    robHead_i   = v.head;
    unitValid_i = v.valid;
    for (int i = 0; i < NU; i++) begin
      unitTag_i[i*TW +: TW]  = tg[i];
      unitVal_i[i*64 +: 64]  = val_of(i, tg[i]);
      unitFlags_i[i*4 +: 4]  = flags_of(i, tg[i]);
    end
    @(negedge clk_i);
    check("canGo", idx, 64'(canGo_o), 64'(v.exp_go));
    @(posedge clk_i);
    #1;
    check("cdbValid", idx, 64'(cdbValid_o), 64'(v.exp_cv));
    if (v.mode == CHK_ZERO) begin
      check("cdbTag",   idx, 64'(cdbTag_o),   64'd0);
      check("cdbUnit",  idx, 64'(cdbUnit_o),  64'd0);
      check("cdbVal",   idx, cdbVal_o,        64'd0);
      check("cdbFlags", idx, 64'(cdbFlags_o), 64'd0);
    end else if (v.mode == CHK_WORD) begin
      check("cdbTag",   idx, 64'(cdbTag_o),   64'(v.exp_tag));
      check("cdbUnit",  idx, 64'(cdbUnit_o),  64'(v.exp_unit));
      check("cdbVal",   idx, cdbVal_o,        val_of(int'(v.exp_unit), v.exp_tag));
      check("cdbFlags", idx, 64'(cdbFlags_o), 64'(flags_of(int'(v.exp_unit), v.exp_tag)));
    end
  endtask

  vec_t tbl [14];

  initial begin
    //            rst flush stall head valid    t0 t1 t2 t3  go       cv  mode      tag unit
    tbl[0]  = mk(1, 0, 0,  0, 4'b1111,  5,  2,  9,  7, 4'b0000, 0, CHK_ZERO,  0, 0);
    tbl[1]  = mk(1, 0, 0,  0, 4'b1111,  5,  2,  9,  7, 4'b0000, 0, CHK_ZERO,  0, 0);
    tbl[2]  = mk(0, 0, 0,  0, 4'b1111,  5,  2,  9,  7, 4'b0010, 1, CHK_WORD,  2, 1);
    tbl[3]  = mk(0, 0, 0, 14, 4'b0111,  1, 15, 13,  0, 4'b0010, 1, CHK_WORD, 15, 1);
    tbl[4]  = mk(0, 0, 0, 14, 4'b0101,  1, 15, 13,  0, 4'b0001, 1, CHK_WORD,  1, 0);
    tbl[5]  = mk(0, 0, 0, 14, 4'b0100,  1, 15, 13,  0, 4'b0100, 1, CHK_WORD, 13, 2);
    tbl[6]  = mk(0, 0, 0, 14, 4'b0000,  1, 15, 13,  0, 4'b0000, 0, CHK_WORD, 13, 2);
    tbl[7]  = mk(0, 0, 0,  0, 4'b0001,  3,  0,  0,  0, 4'b0001, 1, CHK_WORD,  3, 0);
    tbl[8]  = mk(0, 1, 1,  0, 4'b1111,  6,  5,  9,  8, 4'b0000, 0, CHK_ZERO,  0, 0);
    tbl[9]  = mk(0, 0, 0,  0, 4'b0101,  4,  0,  4,  0, 4'b0001, 1, CHK_WORD,  4, 0);
    tbl[10] = mk(1, 0, 0,  0, 4'b1111,  4,  6,  5,  8, 4'b0000, 0, CHK_ZERO,  0, 0);
    tbl[11] = mk(0, 0, 0,  5, 4'b1111,  4,  6,  5,  8, 4'b0100, 1, CHK_WORD,  5, 2);
    tbl[12] = mk(0, 0, 0,  3, 4'b1111,  2, 10, 11,  0, 4'b0010, 1, CHK_WORD, 10, 1);
    tbl[13] = mk(0, 0, 0,  0, 4'b1000,  0,  0,  0,  7, 4'b1000, 1, CHK_WORD,  7, 3);

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], i);
    end

    // Stall: load a tag-3 word, hold it through three stalled cycles, then release.
    apply(mk(0, 0, 0, 0, 4'b1000, 0, 0, 0, 3, 4'b1000, 1, CHK_WORD, 3, 3), 100);
    for (int k = 0; k < 3; k++) begin
      apply(mk(0, 0, 1, 0, 4'b1111, 6, 5, 9, 8, 4'b0000, 1, CHK_WORD, 3, 3), 101 + k);
    end
    apply(mk(0, 0, 0, 0, 4'b1111, 6, 5, 9, 8, 4'b0010, 1, CHK_WORD, 5, 1), 104);

    // Back-to-back: unit 0 keeps the oldest tag for four cycles.
    for (int k = 0; k < 4; k++) begin
      apply(mk(0, 0, 0, 0, 4'b0101, TW'(k), 0, 8, 0, 4'b0001, 1, CHK_WORD, TW'(k), 0), 200 + k);
    end

    // Plain idle cycle after traffic: valid drops, data fields hold.
    apply(mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, CHK_WORD, 3, 0), 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
